// File: rtl/branch_pred_pkg.sv
// Shared definitions for the branch predictor update path.
// Holds the default predictor-table index width and the queue-entry layout.
// The entry carries a fixed-width history field so that one struct type serves
// every IDX_W up to BP_GHR_MAX_W. Users take the low IDX_W bits of that field.
package branch_pred_pkg;

    localparam int unsigned BP_IDX_W     = 8;
    localparam int unsigned BP_GHR_MAX_W = 16;

    typedef struct packed {
        logic [31:0]             pc;
        logic                    taken;
        logic                    pred_taken;
        logic [BP_GHR_MAX_W-1:0] ghr;
    } bp_entry_t;

    localparam int unsigned BP_ENTRY_W = $bits(bp_entry_t);

endpackage

// File: rtl/branch_update_queue_sync_fifo.sv
// sync_fifo: generic single-clock FIFO with a registered occupancy count.
// Parameters: DEPTH (power of two, 2..16) and WIDTH (entry width in bits).
// Ports:
//   i_clk, i_rst_n   clock and asynchronous active-low reset
//   i_push, i_data   write request and data. The write is ignored when the FIFO is full.
//   i_pop            read request. It is ignored when the FIFO is empty.
//   o_data           head entry. It is meaningful only while o_count != 0.
//   o_count, o_full  occupancy and the full flag
// The storage array is not reset. Only the pointers and the count are reset.
module sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push_ok_s, pop_ok_s;

    assign push_ok_s = i_push && (cnt_q != CNT_W'(DEPTH));
    assign pop_ok_s  = i_pop && (cnt_q != {CNT_W{1'b0}});
    assign o_data    = mem_q[rd_q];
    assign o_count   = cnt_q;
    assign o_full    = (cnt_q == CNT_W'(DEPTH));

    // Next-state pointers and count. The pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_ok_s) begin
            wr_d = wr_q + PTR_W'(1);
        end else begin
            wr_d = wr_q;
        end
        if (pop_ok_s) begin
            rd_d = rd_q + PTR_W'(1);
        end else begin
            rd_d = rd_q;
        end
        if (push_ok_s && !pop_ok_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok_s && !push_ok_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_q  <= {PTR_W{1'b0}};
            rd_q  <= {PTR_W{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage.
    always_ff @(posedge i_clk) begin
        if (push_ok_s) begin
            mem_q[wr_q] <= i_data;
        end
    end

endmodule

// File: rtl/branch_update_queue.sv
// branch_update_queue: buffers resolved conditional branches from EX and drains
// them one per cycle into the bias table and the agree-PHT of the predictor.
// Ports:
//   i_clk, i_rst_n                 clock and asynchronous active-low reset
//   i_ex_valid/pc/taken/pred_taken/ghr   branch resolved in EX
//   o_ex_stall                     the queue is full, so EX must hold the branch
//   o_mispredict                   registered pulse for an accepted mispredicted branch
//   i_upd_ready                    the predictor tables accept a write this cycle
//   o_bias_upd_*                   bias-table write. It occurs on the first drain of a given index.
//   o_pht_upd_*                    agree-PHT update. It occurs on every drain.
//   o_stat_branches/o_stat_mispredicts   saturating counters. They exist only when BUQ_STATS_EN is defined.
// Optional feature macro: BUQ_STATS_EN.
// IDX_W must not exceed BP_GHR_MAX_W.
module branch_update_queue
    import branch_pred_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IDX_W = BP_IDX_W
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_ex_pc,
    input  logic             i_ex_taken,
    input  logic             i_ex_pred_taken,
    input  logic [IDX_W-1:0] i_ex_ghr,
    output logic             o_ex_stall,
    output logic             o_mispredict,
    input  logic             i_upd_ready,
    output logic             o_bias_upd_valid,
    output logic [31:0]      o_bias_upd_pc,
    output logic             o_bias_upd_taken,
    output logic             o_pht_upd_valid,
    output logic [IDX_W-1:0] o_pht_upd_idx,
    output logic             o_pht_upd_agree
`ifdef BUQ_STATS_EN
    ,
    output logic [31:0]      o_stat_branches,
    output logic [31:0]      o_stat_mispredicts
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH+1);
    localparam int unsigned TBL_N = 2**IDX_W;

    bp_entry_t        enq_s, head_s;
    logic             push_s, pop_s, full_s;
    logic [CNT_W-1:0] count_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [TBL_N-1:0] seen_q, seen_d, shadow_q, shadow_d;
    logic             mispredict_q, mispredict_d;
    logic             unused_s;

    // The stall depends only on the registered count. A full queue therefore never pushes, even while it drains.
    assign push_s     = i_ex_valid && !full_s;
    assign pop_s      = i_upd_ready && (count_s != {CNT_W{1'b0}});
    assign o_ex_stall = full_s;
    assign head_idx_s = head_s.pc[IDX_W+1:2];
    assign unused_s   = ^{head_s.pred_taken, head_s.ghr};

    // Pack the EX branch into a queue entry.
    always_comb begin
        enq_s            = '0;
        enq_s.pc         = i_ex_pc;
        enq_s.taken      = i_ex_taken;
        enq_s.pred_taken = i_ex_pred_taken;
        enq_s.ghr        = BP_GHR_MAX_W'(i_ex_ghr);
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BP_ENTRY_W)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_s),
        .i_data  (enq_s),
        .i_pop   (pop_s),
        .o_data  (head_s),
        .o_count (count_s),
        .o_full  (full_s)
    );

    // On the first drain of an index, the index becomes seen and records its bias direction.
    always_comb begin
        seen_d       = seen_q;
        shadow_d     = shadow_q;
        mispredict_d = push_s && (i_ex_taken != i_ex_pred_taken);
        if (pop_s && !seen_q[head_idx_s]) begin
            seen_d[head_idx_s]   = 1'b1;
            shadow_d[head_idx_s] = head_s.taken;
        end else begin
            seen_d   = seen_q;
            shadow_d = shadow_q;
        end
    end

    // Update outputs are driven combinationally from the head entry during the drain cycle.
    always_comb begin
        o_bias_upd_valid = pop_s && !seen_q[head_idx_s];
        o_bias_upd_pc    = head_s.pc;
        o_bias_upd_taken = head_s.taken;
        o_pht_upd_valid  = pop_s;
        o_pht_upd_idx    = head_idx_s ^ head_s.ghr[IDX_W-1:0];
        if (seen_q[head_idx_s]) begin
            o_pht_upd_agree = (head_s.taken == shadow_q[head_idx_s]);
        end else begin
            o_pht_upd_agree = 1'b1;
        end
    end

    // Seen and shadow vectors, and the mispredict pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seen_q       <= {TBL_N{1'b0}};
            shadow_q     <= {TBL_N{1'b0}};
            mispredict_q <= 1'b0;
        end else begin
            seen_q       <= seen_d;
            shadow_q     <= shadow_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign o_mispredict = mispredict_q;

`ifdef BUQ_STATS_EN
    logic [31:0] stat_br_q, stat_mp_q;

    // Saturating event counters: accepted branches and mispredict pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            stat_br_q <= 32'd0;
            stat_mp_q <= 32'd0;
        end else begin
            if (push_s && (stat_br_q != 32'hFFFF_FFFF)) begin
                stat_br_q <= stat_br_q + 32'd1;
            end
            if (mispredict_q && (stat_mp_q != 32'hFFFF_FFFF)) begin
                stat_mp_q <= stat_mp_q + 32'd1;
            end
        end
    end

    assign o_stat_branches    = stat_br_q;
    assign o_stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_update_queue.sv
module tb_branch_update_queue;

    localparam int DEPTH = 4;
    localparam int IDX_W = 8;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic             i_ex_valid;
    logic [31:0]      i_ex_pc;
    logic             i_ex_taken;
    logic             i_ex_pred_taken;
    logic [IDX_W-1:0] i_ex_ghr;
    logic             o_ex_stall;
    logic             o_mispredict;
    logic             i_upd_ready;
    logic             o_bias_upd_valid;
    logic [31:0]      o_bias_upd_pc;
    logic             o_bias_upd_taken;
    logic             o_pht_upd_valid;
    logic [IDX_W-1:0] o_pht_upd_idx;
    logic             o_pht_upd_agree;
`ifdef BUQ_STATS_EN
    logic [31:0]      o_stat_branches;
    logic [31:0]      o_stat_mispredicts;
`endif

    branch_update_queue #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .i_clk            (i_clk),
        .i_rst_n          (i_rst_n),
        .i_ex_valid       (i_ex_valid),
        .i_ex_pc          (i_ex_pc),
        .i_ex_taken       (i_ex_taken),
        .i_ex_pred_taken  (i_ex_pred_taken),
        .i_ex_ghr         (i_ex_ghr),
        .o_ex_stall       (o_ex_stall),
        .o_mispredict     (o_mispredict),
        .i_upd_ready      (i_upd_ready),
        .o_bias_upd_valid (o_bias_upd_valid),
        .o_bias_upd_pc    (o_bias_upd_pc),
        .o_bias_upd_taken (o_bias_upd_taken),
        .o_pht_upd_valid  (o_pht_upd_valid),
        .o_pht_upd_idx    (o_pht_upd_idx),
        .o_pht_upd_agree  (o_pht_upd_agree)
`ifdef BUQ_STATS_EN
        ,
        .o_stat_branches    (o_stat_branches),
        .o_stat_mispredicts (o_stat_mispredicts)
`endif
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0]      pc;
        logic             bias_v;
        logic             taken;
        logic [IDX_W-1:0] idx;
        logic             agree;
    } exp_t;

    exp_t sb[$];
    logic m_seen   [2**IDX_W];
    logic m_shadow [2**IDX_W];
    int   cnt;
    int   checks   = 0;
    int   failures = 0;
    int   st_br    = 0;
    int   st_mp    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        cnt   = 0;
        st_br = 0;
        st_mp = 0;
        for (int i = 0; i < 2**IDX_W; i++) begin
            m_seen[i]   = 1'b0;
            m_shadow[i] = 1'b0;
        end
    endtask

    // Called at a negedge: assert reset, check the quiet outputs, and release the reset one cycle later.
    task automatic do_reset();
        i_rst_n     = 1'b0;
        i_ex_valid  = 1'b1;
        i_upd_ready = 1'b1;
        #1;
        chk("rst_stall", o_ex_stall, 1'b0);
        chk("rst_pht_valid", o_pht_upd_valid, 1'b0);
        chk("rst_bias_valid", o_bias_upd_valid, 1'b0);
        @(negedge i_clk);
        chk("rst_mispredict", o_mispredict, 1'b0);
        chk("rst_pht_valid2", o_pht_upd_valid, 1'b0);
        i_rst_n    = 1'b1;
        i_ex_valid = 1'b0;
        model_clear();
    endtask

    // One cycle starting at a negedge. The task drives the inputs, checks the combinational outputs
    // against the queue model, and checks o_mispredict at the next negedge.
    task automatic tick(input logic v, input logic [31:0] pc, input logic t, input logic p,
                        input logic [IDX_W-1:0] g, input logic r);
        exp_t             e;
        logic             acc, drn;
        logic [IDX_W-1:0] ix;
        i_ex_valid      = v;
        i_ex_pc         = pc;
        i_ex_taken      = t;
        i_ex_pred_taken = p;
        i_ex_ghr        = g;
        i_upd_ready     = r;
        #1;
        chk("stall", o_ex_stall, (cnt == DEPTH));
        drn = r && (cnt != 0);
        chk("pht_valid", o_pht_upd_valid, drn);
        if (drn && sb.size() != 0) begin
            e = sb.pop_front();
            chk("bias_valid", o_bias_upd_valid, e.bias_v);
            chk("bias_pc", o_bias_upd_pc, e.pc);
            if (e.bias_v) chk("bias_taken", o_bias_upd_taken, e.taken);
            chk("pht_idx", o_pht_upd_idx, e.idx);
            chk("pht_agree", o_pht_upd_agree, e.agree);
        end else begin
            chk("bias_idle", o_bias_upd_valid, 1'b0);
        end
        acc = v && (cnt != DEPTH);
        if (acc) begin
            ix       = pc[IDX_W+1:2];
            e.pc     = pc;
            e.bias_v = !m_seen[ix];
            e.taken  = t;
            e.idx    = ix ^ g;
            e.agree  = m_seen[ix] ? (t == m_shadow[ix]) : 1'b1;
            if (!m_seen[ix]) begin
                m_seen[ix]   = 1'b1;
                m_shadow[ix] = t;
            end
            sb.push_back(e);
            st_br++;
        end
        cnt = cnt + (acc ? 1 : 0) - (drn ? 1 : 0);
        @(negedge i_clk);
        chk("mispredict", o_mispredict, acc && (t != p));
        if (acc && (t != p)) st_mp++;
        i_ex_valid = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_ex_valid = 1'b0; i_ex_pc = 32'd0; i_ex_taken = 1'b0;
        i_ex_pred_taken = 1'b0; i_ex_ghr = 8'd0; i_upd_ready = 1'b0;
        model_clear();
        do_reset();

        // First branch at pc 0x100 (index 0x40) mispredicts, then drains with a bias write.
        tick(1'b1, 32'h100, 1'b1, 1'b0, 8'h05, 1'b1);
        tick(1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1);
        // The same pc with the opposite outcome: no bias write, and the update disagrees.
        tick(1'b1, 32'h100, 1'b0, 1'b0, 8'h05, 1'b1);
        tick(1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1);

        // Fill the queue while not ready. The fifth branch is held until the first drain.
        tick(1'b1, 32'h200, 1'b1, 1'b1, 8'h11, 1'b0);
        tick(1'b1, 32'h204, 1'b0, 1'b1, 8'h22, 1'b0);
        tick(1'b1, 32'h208, 1'b1, 1'b0, 8'h33, 1'b0);
        tick(1'b1, 32'h20C, 1'b0, 1'b0, 8'h44, 1'b0);
        tick(1'b1, 32'h210, 1'b1, 1'b0, 8'h55, 1'b0);
        tick(1'b1, 32'h210, 1'b1, 1'b0, 8'h55, 1'b1);
        tick(1'b1, 32'h210, 1'b1, 1'b0, 8'h55, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Enqueue and drain in the same cycle at count 2. Two entries share index 0xC0.
        tick(1'b1, 32'h300, 1'b1, 1'b1, 8'h0F, 1'b0);
        tick(1'b1, 32'h300, 1'b1, 1'b1, 8'hF0, 1'b0);
        tick(1'b1, 32'h400, 1'b0, 1'b1, 8'hAA, 1'b1);
        tick(1'b1, 32'h404, 1'b0, 1'b0, 8'h01, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset while three entries are queued. The entries vanish and the seen bits are cleared.
        tick(1'b1, 32'h500, 1'b1, 1'b0, 8'h01, 1'b0);
        tick(1'b1, 32'h504, 1'b1, 1'b1, 8'h02, 1'b0);
        tick(1'b1, 32'h508, 1'b0, 1'b1, 8'h03, 1'b0);
        do_reset();
        tick(1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b1, 32'h100, 1'b0, 1'b0, 8'h07, 1'b1);
        tick(1'b0, 32'h0,   1'b0, 1'b0, 8'h00, 1'b1);

        // Ten branches, of which three are mispredicted.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 32'h600 + 32'(4 * i), 1'b1, (i % 3 == 2) ? 1'b0 : 1'b1, 8'(i), 1'b1);
        end
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0, 1'b0, 8'h00, 1'b1);
`ifdef BUQ_STATS_EN
        chk("stat_branches", o_stat_branches, 32'd10);
        chk("stat_mispredicts", o_stat_mispredicts, 32'd3);
        chk("stat_branches_model", o_stat_branches, 32'(st_br));
        chk("stat_mispredicts_model", o_stat_mispredicts, 32'(st_mp));
`endif
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
